arrow_scroller: RTL and testbench
=================================

Name: arrow_scroller

Overview:
Upstream feeder for the VGA index stage. It produces the 78-bit arrow_array (26 slots × 3-bit arrow codes) and the two 2-bit player indicators that the index stage draws. These values are currently hard-wired constants.
- Scrolls arrows one slot per step; a step is a fixed number of video frames.
- Spawns new arrows pseudo-randomly at the top slot.
- Judges both players' button presses against the bottom slot and keeps saturating scores.

Parameters:
SLOTS, 26, number of arrow slots (array width = SLOTS*CODE_W)
CODE_W, 3, bits per slot code
FRAMES_PER_STEP, 8, frames between scroll steps (≥1)
LFSR_SEED, 16'hACE1, reset value of spawn LFSR (nonzero)

Ports:
clock  in  1  pixel clock (same as the sync generator)
reset  in  1  synchronous, active-high
vs_n  in  1  vertical sync from sync generator, active low
start  in  1  level; begins play from IDLE
stop  in  1  level; ends spawning from RUN
p1_btn  in  4  player 1 buttons {right,up,down,left}, active high
p2_btn  in  4  player 2 buttons, same encoding
arrow_array  out  78  slot k occupies bits [3k+2:3k]; slot 0 = bottom/target
p1_indicator  out  2  00 none, 01 hit, 10 miss, 11 wrong
p2_indicator  out  2  same encoding
p1_score  out  8  saturating hit count
p2_score  out  8  saturating hit count
step  out  1  one-cycle pulse on every scroll step
busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset (sync, active-high):
  - All outputs 0; state IDLE.
  - LFSR = LFSR_SEED; frame counter 0.
  - Button/vs_n history registers 0 and 1 respectively.
- Codes: 0 empty; 1 left, 2 down, 3 up, 4 right; 5–7 reserved, treated as empty for judging, never generated.
- Frame tick: one cycle after vs_n goes 1→0 (registered edge detect).
  - Frame counter counts ticks 0..FRAMES_PER_STEP-1, only in RUN/DRAIN.
  - Wrap produces a step; the step pulse is registered, asserted the cycle after the wrapping tick.
- Step action, all applied in the step cycle:
  - Slot k ← slot k+1 for k = 0..SLOTS-2.
  - Top slot ← spawn code.
  - 16-bit Fibonacci LFSR (taps 16,14,13,11) advances once.
- Spawn code:
  - RUN: if lfsr[3:0] < 6, code lfsr[5:4]+1; otherwise 0.
  - DRAIN: always 0.
- States:
  - IDLE: array held 0. start=1 → RUN; frame counter, scores and indicators cleared on entry.
  - RUN: stop=1 → DRAIN (takes precedence over start).
  - DRAIN: when a step leaves arrow_array all-zero → IDLE. start is ignored in DRAIN.
- Judging, per player and independent:
  - A press is a rising edge of any p*_btn bit (registered compare), and is evaluated only in RUN/DRAIN.
  - If the player's judged flag is clear and slot 0 holds code c in 1..4:
    - Exactly one risen bit, and it is bit c-1 → hit: indicator 01, score +1 saturating at 255, judged flag set.
    - Any other risen pattern → wrong: indicator 11, judged flag set.
  - Press while slot 0 is empty/reserved, or judged flag already set → ignored.
- Miss: on a step, if slot 0 (pre-shift) holds 1..4 and the player's judged flag is clear → indicator 10. The judged flag is then cleared for the new slot 0.
- Press and step in the same cycle: the press is judged against pre-shift slot 0 first. A hit/wrong in that cycle suppresses the miss. The indicator shows the press result.
- Indicators hold their last value until the next event. They are cleared only on reset or IDLE→RUN.
- Latency: arrow_array changes one cycle after the step-generating tick. The index stage samples it asynchronously to pixel position, so tearing within a frame is accepted.
- vs_n held low: only a single tick is generated.

Decomposition:
- Shared package arrow_pkg: code localparams (EMPTY, LEFT, DOWN, UP, RIGHT), indicator encodings, state enum (IDLE/RUN/DRAIN), SLOTS/CODE_W defaults.
- One natural sub-module, arrow_judge: per-player edge detect, judged flag, indicator and score; instantiated twice.

Test Plan:
- Reset mid-RUN with arrows present → next cycle: array 0, scores 0, indicators 00, busy 0. Then start and FRAMES_PER_STEP=8 → first step pulse exactly one cycle after the 8th vs_n falling edge following start.
- Force LFSR_SEED so the first spawn is code 3 → after a step, bits [77:75]=3. After 25 more steps, slot 0 = 3.
- Slot 0 = 3 (up), p1_btn 0000→0100 → p1_indicator 01, p1_score 1. A second press before the step → no change. p2 idle through the step → p2_indicator 10.
- Slot 0 = 1, p1_btn 0000→0011 → p1_indicator 11, score unchanged, no miss at the next step.
- Press of the matching button in the same cycle as a step → hit recorded, indicator 01 (not 10), judged flag clear for the new slot 0.
- p1 score at 255 plus a hit → stays 255. Then stop → DRAIN, no new spawns; after ≤26 steps the array is 0, state IDLE, busy 0. start asserted during DRAIN is ignored.

Source files
------------

// File: rtl/arrow_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arrow_pkg
// Brief    : Shared arrow codes, indicator encodings and play-state enum.
// Revision : 1.0
// ============================================================================
package arrow_pkg;

    localparam int DEF_SLOTS  = 26;
    localparam int DEF_CODE_W = 3;

    localparam logic [2:0] EMPTY = 3'd0;
    localparam logic [2:0] LEFT  = 3'd1;
    localparam logic [2:0] DOWN  = 3'd2;
    localparam logic [2:0] UP    = 3'd3;
    localparam logic [2:0] RIGHT = 3'd4;

    localparam logic [1:0] IND_NONE  = 2'b00;
    localparam logic [1:0] IND_HIT   = 2'b01;
    localparam logic [1:0] IND_MISS  = 2'b10;
    localparam logic [1:0] IND_WRONG = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Reserved codes 5..7 count as empty for judging.
    function automatic logic is_arrow(input logic [2:0] code);
        return (code >= LEFT) && (code <= RIGHT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arrow_judge.sv
`default_nettype none
// ============================================================================
// Module   : arrow_judge
// Brief    : Per-player press edge detect, judged flag, indicator and score.
// Revision : 1.0
// ============================================================================
module arrow_judge
    import arrow_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_active,
    input  logic       i_step,
    input  logic [2:0] i_slot0,
    input  logic [3:0] i_btn,
    output logic [1:0] o_indicator,
    output logic [7:0] o_score
);

    logic [3:0] r_btn_d;
    logic       r_judged;
    logic [1:0] r_ind;
    logic [7:0] r_score;

    logic [3:0] w_rise;
    logic [3:0] w_target;
    logic       w_valid;
    logic       w_press;
    logic       w_hit;

    assign w_rise   = i_btn & ~r_btn_d;
    assign w_valid  = is_arrow(i_slot0);
    // Codes 1..4 map to button bits 0..3; code 4 wraps through 2'b00 - 1.
    assign w_target = 4'b0001 << (i_slot0[1:0] - 2'd1);
    assign w_press  = i_active & (|w_rise) & ~r_judged & w_valid;
    assign w_hit    = w_press & (w_rise == w_target);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_d  <= 4'd0;
            r_judged <= 1'b0;
            r_ind    <= IND_NONE;
            r_score  <= 8'd0;
        end else begin
            r_btn_d <= i_btn;
            if (i_clear) begin
                r_judged <= 1'b0;
                r_ind    <= IND_NONE;
                r_score  <= 8'd0;
            end else begin
                if (w_press) begin
                    r_ind <= w_hit ? IND_HIT : IND_WRONG;
                    if (w_hit && (r_score != 8'hFF)) begin
                        r_score <= r_score + 8'd1;
                    end
                end
                // A press in the step cycle is judged against the outgoing slot 0.
                if (i_step) begin
                    if (!w_press && w_valid && !r_judged) begin
                        r_ind <= IND_MISS;
                    end
                    r_judged <= 1'b0;
                end else if (w_press) begin
                    r_judged <= 1'b1;
                end
            end
        end
    end

    assign o_indicator = r_ind;
    assign o_score     = r_score;

endmodule
`default_nettype wire

// File: rtl/arrow_scroller.sv
`default_nettype none
// ============================================================================
// Module   : arrow_scroller
// Brief    : Frame-paced arrow scroller with LFSR spawning and two judges.
// Revision : 1.0
// ============================================================================
module arrow_scroller
    import arrow_pkg::*;
#(
    parameter int          SLOTS           = DEF_SLOTS,
    parameter int          CODE_W          = DEF_CODE_W,
    parameter int          FRAMES_PER_STEP = 8,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    vs_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [3:0]              p1_btn,
    input  logic [3:0]              p2_btn,
    output logic [SLOTS*CODE_W-1:0] arrow_array,
    output logic [1:0]              p1_indicator,
    output logic [1:0]              p2_indicator,
    output logic [7:0]              p1_score,
    output logic [7:0]              p2_score,
    output logic                    step,
    output logic                    busy
);

    localparam int ARR_W = SLOTS * CODE_W;
    localparam int FC_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    state_t            r_state;
    logic [ARR_W-1:0]  r_array;
    logic [15:0]       r_lfsr;
    logic [FC_W-1:0]   r_frame;
    logic              r_vs_d;
    logic              r_step;
    logic              r_busy;

    logic              w_tick;
    logic              w_active;
    logic              w_wrap;
    logic              w_adv;
    logic              w_enter_run;
    logic [CODE_W-1:0] w_spawn;
    logic [ARR_W-1:0]  w_next_array;
    logic              w_next_zero;
    logic [15:0]       w_lfsr_next;

    assign w_tick       = r_vs_d & ~vs_n;
    assign w_active     = (r_state != IDLE);
    assign w_wrap       = (r_frame == FC_W'(FRAMES_PER_STEP - 1));
    assign w_adv        = w_active & w_tick & w_wrap;
    assign w_enter_run  = (r_state == IDLE) & start;
    assign w_spawn      = ((r_state == RUN) && (r_lfsr[3:0] < 4'd6))
                        ? CODE_W'(r_lfsr[5:4]) + CODE_W'(1)
                        : CODE_W'(EMPTY);
    assign w_next_array = {w_spawn, r_array[ARR_W-1:CODE_W]};
    assign w_next_zero  = (w_next_array == '0);
    assign w_lfsr_next  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_array <= '0;
            r_lfsr  <= LFSR_SEED;
            r_frame <= '0;
            r_vs_d  <= 1'b1;
            r_step  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_vs_d <= vs_n;
            r_step <= w_adv;
            if (w_active && w_tick) begin
                r_frame <= w_wrap ? '0 : r_frame + FC_W'(1);
            end
            if (w_adv) begin
                r_array <= w_next_array;
                r_lfsr  <= w_lfsr_next;
            end
            case (r_state)
                IDLE: begin
                    r_array <= '0;
                    if (start) begin
                        r_state <= RUN;
                        r_frame <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_adv && w_next_zero) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    arrow_judge u_judge_p1 (
        .clk         (clock),
        .rst         (reset),
        .i_clear     (w_enter_run),
        .i_active    (w_active),
        .i_step      (w_adv),
        .i_slot0     (r_array[2:0]),
        .i_btn       (p1_btn),
        .o_indicator (p1_indicator),
        .o_score     (p1_score)
    );

    arrow_judge u_judge_p2 (
        .clk         (clock),
        .rst         (reset),
        .i_clear     (w_enter_run),
        .i_active    (w_active),
        .i_step      (w_adv),
        .i_slot0     (r_array[2:0]),
        .i_btn       (p2_btn),
        .o_indicator (p2_indicator),
        .o_score     (p2_score)
    );

    assign arrow_array = r_array;
    assign step        = r_step;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_arrow_scroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_arrow_scroller
// Brief    : Randomised bench with a slot-list reference model of the scroller.
// Revision : 1.0
// ============================================================================
module tb_arrow_scroller;

    localparam int SLOTS  = 26;
    localparam int CODE_W = 3;
    localparam int ARR_W  = SLOTS * CODE_W;
    localparam int FPS    = 8;
    localparam int VP     = 3;
    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             vs_n  = 1'b1;
    logic             start = 1'b0;
    logic             stop  = 1'b0;
    logic [3:0]       p1_btn = 4'd0;
    logic [3:0]       p2_btn = 4'd0;
    logic [ARR_W-1:0] arrow_array;
    logic [1:0]       p1_indicator, p2_indicator;
    logic [7:0]       p1_score, p2_score;
    logic             step, busy;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    arrow_scroller #(
        .SLOTS(SLOTS), .CODE_W(CODE_W), .FRAMES_PER_STEP(FPS), .LFSR_SEED(16'hACE1)
    ) dut (
        .clock(clock), .reset(reset), .vs_n(vs_n), .start(start), .stop(stop),
        .p1_btn(p1_btn), .p2_btn(p2_btn), .arrow_array(arrow_array),
        .p1_indicator(p1_indicator), .p2_indicator(p2_indicator),
        .p1_score(p1_score), .p2_score(p2_score), .step(step), .busy(busy)
    );

    initial forever #5 clock = ~clock;

    // Reference model: slot list, frame count and scores kept as plain integers.
    int m_slot [SLOTS];
    int m_state, m_frame, m_lfsr;
    int m_bd [2], m_jud [2], m_ind [2], m_sc [2];
    bit m_vsd, m_step, m_busy;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  btn [2];
        int  rise, c, sp;
        bit  fall, adv, act, pressed, hit, allz;
        btn[0] = int'(p1_btn);
        btn[1] = int'(p2_btn);
        if (reset) begin
            for (int k = 0; k < SLOTS; k++) m_slot[k] = 0;
            m_state = S_IDLE; m_frame = 0; m_lfsr = 'hACE1; m_vsd = 1'b1;
            for (int p = 0; p < 2; p++) begin
                m_bd[p] = 0; m_jud[p] = 0; m_ind[p] = 0; m_sc[p] = 0;
            end
            m_step = 1'b0; m_busy = 1'b0;
        end else begin
            act  = (m_state != S_IDLE);
            fall = m_vsd && !vs_n;
            adv  = act && fall && (m_frame == FPS - 1);
            c    = m_slot[0];
            for (int p = 0; p < 2; p++) begin
                rise    = btn[p] & ~m_bd[p] & 15;
                pressed = act && (rise != 0) && (m_jud[p] == 0) && (c >= 1) && (c <= 4);
                if (pressed) begin
                    hit = (rise == (1 << (c - 1)));
                    m_ind[p] = hit ? 1 : 3;
                    if (hit && m_sc[p] < 255) m_sc[p]++;
                end
                if (adv) begin
                    if (!pressed && c >= 1 && c <= 4 && m_jud[p] == 0) m_ind[p] = 2;
                    m_jud[p] = 0;
                end else if (pressed) begin
                    m_jud[p] = 1;
                end
                m_bd[p] = btn[p];
            end
            if (adv) begin
                sp = (m_state == S_RUN && (m_lfsr & 15) < 6) ? ((m_lfsr >> 4) & 3) + 1 : 0;
                for (int k = 0; k < SLOTS - 1; k++) m_slot[k] = m_slot[k + 1];
                m_slot[SLOTS - 1] = sp;
                m_lfsr = ((m_lfsr << 1) |
                          (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1))
                         & 'hFFFF;
            end
            allz = 1'b1;
            for (int k = 0; k < SLOTS; k++) if (m_slot[k] != 0) allz = 1'b0;
            if (act && fall) m_frame = (m_frame == FPS - 1) ? 0 : m_frame + 1;
            m_step = adv;
            case (m_state)
                S_IDLE: if (start) begin
                    m_state = S_RUN; m_frame = 0;
                    for (int p = 0; p < 2; p++) begin m_ind[p] = 0; m_sc[p] = 0; m_jud[p] = 0; end
                end
                S_RUN:  if (stop) m_state = S_DRAIN;
                default: if (adv && allz) m_state = S_IDLE;
            endcase
            m_busy = (m_state != S_IDLE);
            m_vsd  = vs_n;
        end
    endtask

    task automatic compare();
        logic [ARR_W-1:0] ea;
        for (int k = 0; k < SLOTS; k++) ea[k*CODE_W +: CODE_W] = CODE_W'(m_slot[k]);
        chk("array",  80'(arrow_array),  80'(ea));
        chk("p1_ind", 80'(p1_indicator), 80'(m_ind[0]));
        chk("p2_ind", 80'(p2_indicator), 80'(m_ind[1]));
        chk("p1_sc",  80'(p1_score),     80'(m_sc[0]));
        chk("p2_sc",  80'(p2_score),     80'(m_sc[1]));
        chk("step",   80'(step),         80'(m_step));
        chk("busy",   80'(busy),         80'(m_busy));
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(posedge clock);
        #1;
        if (cmp_en) compare();
    end

    int vcnt = 1;
    bit count_falls = 1'b0;
    int falls = 0, fall_at = -1, cyc_no = 0;

    task automatic cyc(input logic [3:0] b1, input logic [3:0] b2, input logic st, input logic sp);
        @(negedge clock);
        p1_btn = b1; p2_btn = b2; start = st; stop = sp;
        vcnt = (vcnt + 1) % VP;
        vs_n = (vcnt != 0);
        cyc_no++;
        if (vcnt == 0 && count_falls) begin falls++; fall_at = cyc_no; end
        @(posedge clock);
        #2;
    endtask

    function automatic bit fall_next();
        return ((vcnt + 1) % VP) == 0;
    endfunction

    function automatic logic [3:0] bot();
        if (m_state != S_IDLE && m_slot[0] >= 1 && m_slot[0] <= 4 && m_jud[0] == 0 && p1_btn == 4'd0)
            return 4'(1 << (m_slot[0] - 1));
        return 4'd0;
    endfunction

    task automatic wait_step(input string nm, input logic st);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            cyc(4'd0, 4'd0, st, 1'b0);
            got = step;
        end
        chk({nm, "_step_seen"}, 80'(got), 80'd1);
    endtask

    initial begin
        int  step_at, n;
        bit  got;
        logic [3:0] b1, b2;

        cyc(4'd0, 4'd0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        cyc(4'd0, 4'd0, 1'b0, 1'b0);
        chk("rst_array", 80'(arrow_array), 80'd0);
        chk("rst_busy",  80'(busy),        80'd0);
        chk("rst_ind",   80'({p1_indicator, p2_indicator}), 80'd0);
        chk("rst_score", 80'({p1_score, p2_score}), 80'd0);
        reset = 1'b0;
        cyc(4'd0, 4'd0, 1'b0, 1'b0);
        while (fall_next()) cyc(4'd0, 4'd0, 1'b0, 1'b0);

        // First step follows the 8th falling vs_n after start.
        cyc(4'd0, 4'd0, 1'b1, 1'b0);
        count_falls = 1'b1;
        step_at = -1;
        for (int i = 0; i < 100 && step_at < 0; i++) begin
            cyc(4'd0, 4'd0, 1'b0, 1'b0);
            if (step) step_at = cyc_no;
        end
        count_falls = 1'b0;
        chk("first_step_falls", 80'(falls), 80'd8);
        chk("first_step_cycle", 80'(step_at), 80'(fall_at));
        chk("first_spawn_top",  80'(arrow_array[ARR_W-1 -: 3]), 80'd3);
        chk("first_spawn_rest", 80'(arrow_array[ARR_W-4:0]), 80'd0);

        for (int i = 0; i < 25; i++) wait_step("scroll", 1'b0);
        chk("arrival_slot0", 80'(arrow_array[2:0]), 80'd3);
        chk("arrival_ind",   80'({p1_indicator, p2_indicator}), 80'd0);

        cyc(4'b0100, 4'd0, 1'b0, 1'b0);
        chk("hit_ind",   80'(p1_indicator), 80'd1);
        chk("hit_score", 80'(p1_score),     80'd1);
        cyc(4'd0, 4'd0, 1'b0, 1'b0);
        cyc(4'b0100, 4'd0, 1'b0, 1'b0);
        chk("repress_ind",   80'(p1_indicator), 80'd1);
        chk("repress_score", 80'(p1_score),     80'd1);
        wait_step("hit_step", 1'b0);
        chk("p2_miss",       80'(p2_indicator), 80'd2);
        chk("p1_keeps_hit",  80'(p1_indicator), 80'd1);

        // Wrong press: two buttons against a LEFT arrow.
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            wait_step("seek_left", 1'b0);
            got = (m_slot[0] == 1);
        end
        chk("seek_left_found", 80'(got), 80'd1);
        cyc(4'b0011, 4'd0, 1'b0, 1'b0);
        chk("wrong_ind",   80'(p1_indicator), 80'd3);
        chk("wrong_score", 80'(p1_score),     80'd1);
        cyc(4'd0, 4'd0, 1'b0, 1'b0);
        wait_step("wrong_step", 1'b0);
        chk("wrong_no_miss", 80'(p1_indicator), 80'd3);

        // Matching press in the very cycle of a step, with another arrow next in line.
        got = 1'b0;
        for (int i = 0; i < 8000 && !got; i++) begin
            if (fall_next() && m_state != S_IDLE && m_frame == FPS - 1 &&
                m_slot[0] >= 1 && m_slot[0] <= 4 && m_slot[1] >= 1 && m_slot[1] <= 4 &&
                m_jud[0] == 0) begin
                cyc(4'(1 << (m_slot[0] - 1)), 4'd0, 1'b0, 1'b0);
                got = 1'b1;
            end else begin
                cyc(4'd0, 4'd0, 1'b0, 1'b0);
            end
        end
        chk("same_found", 80'(got), 80'd1);
        chk("same_step",  80'(step),         80'd1);
        chk("same_ind",   80'(p1_indicator), 80'd1);
        chk("same_score", 80'(p1_score),     80'd2);
        wait_step("after_same", 1'b0);
        chk("after_same_miss", 80'(p1_indicator), 80'd2);

        // Bot plays p1 to saturation while p2 presses at random.
        for (int i = 0; i < 40000 && m_sc[0] < 255; i++) begin
            b1 = bot();
            b2 = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            cyc(b1, b2, 1'b0, 1'b0);
        end
        chk("sat_reached", 80'(p1_score), 80'd255);
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            b1 = bot();
            got = (b1 != 4'd0);
            cyc(b1, 4'd0, 1'b0, 1'b0);
        end
        chk("sat_hit_ind", 80'(p1_indicator), 80'd1);
        chk("sat_hold",    80'(p1_score),     80'd255);

        // Reset mid-RUN with arrows and a full score.
        chk("pre_rst_busy", 80'(busy), 80'd1);
        reset = 1'b1;
        cyc(4'd0, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("mid_rst_array", 80'(arrow_array), 80'd0);
        chk("mid_rst_score", 80'({p1_score, p2_score}), 80'd0);
        chk("mid_rst_ind",   80'({p1_indicator, p2_indicator}), 80'd0);
        chk("mid_rst_busy",  80'(busy), 80'd0);

        cyc(4'd0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) wait_step("refill", 1'b0);

        // Stop, then hold start during DRAIN: it must not restart play.
        cyc(4'd0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(4'd0, 4'd0, 1'b1, 1'b0);
            chk("drain_busy", 80'(busy), 80'd1);
        end
        n = 0;
        for (int i = 0; i < 30 && busy; i++) begin
            wait_step("drain", 1'b0);
            n++;
            chk("drain_no_spawn", 80'(arrow_array[ARR_W-1 -: 3]), 80'd0);
        end
        chk("drain_idle",   80'(busy), 80'd0);
        chk("drain_empty",  80'(arrow_array), 80'd0);
        chk("drain_bound",  80'(n <= SLOTS), 80'd1);
        for (int i = 0; i < 30; i++) cyc(4'd0, 4'd0, 1'b0, 1'b0);
        chk("idle_stays", 80'(busy), 80'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
